mdu_sequencer: RTL
==================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk_i input 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_i input 1, reset; synchronous, active-high.
REQ-004 SHALL have port: start_i input 1, request to begin an RV32M op; sampled only in IDLE.
REQ-005 SHALL have port: funct3_i input 3, RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: rs1_i input XLEN, operand A (multiplicand/dividend).
REQ-007 SHALL have port: rs2_i input XLEN, operand B (multiplier/divisor).
REQ-008 SHALL have port: busy_o output 1, high in every state except IDLE; the core stalls its PC on it.
REQ-009 SHALL have port: done_o output 1, one-cycle pulse marking result_o valid.
REQ-010 SHALL have port: result_o output XLEN, registered result; holds its value until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-012 IDLE + start_i=1 SHALL latch funct3_i, rs1_i and rs2_i, then go to PREP; start_i=0 SHALL stay in IDLE.
REQ-013 PREP SHALL form operand magnitudes per signedness and record the result sign, then go to CALC; iteration counter SHALL load 31.
REQ-014 PREP SHALL go directly to DONE for special cases, bypassing CALC and FIX.
- Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
- Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-015 CALC SHALL perform one radix-2 step per cycle for exactly 32 cycles.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract into quotient/remainder.
- Counter decrements each cycle; go to FIX when the counter is 0.
REQ-016 FIX SHALL apply sign correction and select the result, then go to DONE.
- Two's-complement negate the 64-bit product or the quotient when the result sign is negative; the remainder takes the dividend's sign.
- MUL gives the low 32 bits; MULH/MULHSU/MULHU give the high 32 bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
REQ-017 DONE SHALL assert done_o for exactly one cycle with result_o valid, then return to IDLE.
REQ-018 Normal-path latency: done_o SHALL be high in the 35th cycle after the accepting edge (PREP 1 + CALC 32 + FIX 1 + DONE 1).
REQ-019 Special-case latency: done_o SHALL be high in the 2nd cycle after the accepting edge.
REQ-020 start_i SHALL be ignored in every state other than IDLE, including DONE; there is no queuing.
REQ-021 A start_i asserted in the cycle after DONE SHALL be accepted normally, giving back-to-back ops with one IDLE cycle between them.
REQ-022 Operand changes on rs1_i, rs2_i or funct3_i after acceptance SHALL NOT affect the in-flight op.
REQ-023 All arithmetic SHALL be modulo 2^64 internally and modulo 2^32 at result_o; there are no exceptions or flags.

Reset
REQ-024 rst_i=1 at a rising edge SHALL force IDLE, busy_o=0, done_o=0, result_o=0, counter=0 and clear all operand registers.
REQ-025 Reset mid-operation, in any state, SHALL abort the op with no done_o pulse.
REQ-026 The first start_i after reset deasserts SHALL be accepted normally.
REQ-027 rst_i SHALL have priority over start_i in the same cycle.

Structure
REQ-028 The shared package riscv_pkg SHALL hold the mdu_op_e enum (the eight funct3 encodings) and the XLEN constant.
REQ-029 The mdu_state_e FSM enum SHALL be local to the module.
REQ-030 No sub-module SHALL be used; the FSM, counter and iterative datapath reside in mdu_sequencer.
REQ-031 RTL SHALL be synthesizable with one sequential block and one next-state combinational block, and SHALL contain no latches.

Verification
REQ-032 The bench SHALL cover MUL with rs1=7, rs2=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done_o pulse 35 cycles after start, busy_o high for 35 cycles.
REQ-033 The bench SHALL cover MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULH with the same operands -> 0x00000000.
REQ-034 The bench SHALL cover DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, and DIVU 100/7 -> 14 and REMU 100/7 -> 2.
REQ-035 The bench SHALL cover the special cases, each with done_o 2 cycles after start.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 The bench SHALL cover rst_i pulsed in CALC cycle 10 -> next cycle IDLE, busy_o=0, result_o=0, no done_o pulse; a new MUL 3x4 then returns 12.
REQ-037 The bench SHALL cover start_i held high throughout -> exactly one op per 36 cycles, and rs1_i changed mid-CALC -> result unaffected.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width and the RV32M funct3 operation encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  // Divide and remainder ops all carry funct3[2] = 1.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle.
// Signed operands are converted to magnitudes in PREP, the unsigned core runs
// for 32 CALC cycles, and FIX restores the sign and picks the result half.
module mdu_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;        // latched rs1, then |A| (multiplicand / dividend)
  logic [XLEN-1:0]     b_q, b_d;        // latched rs2, then |B| (multiplier / divisor)
  logic [2*XLEN-1:0]   acc_q, acc_d;    // mul: {hi, multiplier}; div: {remainder, quotient}
  logic [4:0]          cnt_q, cnt_d;
  logic                qneg_q, qneg_d;  // product / quotient must be negated
  logic                rneg_q, rneg_d;  // remainder must be negated (dividend sign)
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                a_neg_s;
  logic                b_neg_s;
  logic [XLEN-1:0]     a_mag_s;
  logic [XLEN-1:0]     b_mag_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_shift_s;
  logic [XLEN:0]       div_diff_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s;
  logic [XLEN-1:0]     rem_s;

  // Next-state, datapath step and output-register computation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    result_d    = result_q;

    a_neg_s     = op_signed_a(op_q) & a_q[XLEN-1];
    b_neg_s     = op_signed_b(op_q) & b_q[XLEN-1];
    a_mag_s     = a_neg_s ? (~a_q + 32'd1) : a_q;
    b_mag_s     = b_neg_s ? (~b_q + 32'd1) : b_q;
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, b_q};
    prod_s      = qneg_q ? (~acc_q + 64'd1) : acc_q;
    quo_s       = qneg_q ? (~acc_q[XLEN-1:0] + 32'd1) : acc_q[XLEN-1:0];
    rem_s       = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 32'd1) : acc_q[2*XLEN-1:XLEN];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = mdu_op_e'(funct3_i);
          a_d     = rs1_i;
          b_d     = rs2_i;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PREP: begin
        if (op_is_div(op_q) && (b_q == 32'd0)) begin
          // Divide by zero: quotient all-ones, remainder is the dividend.
          result_d = ((op_q == MDU_DIV) || (op_q == MDU_DIVU)) ? 32'hFFFF_FFFF : a_q;
          state_d  = S_DONE;
        end else if (((op_q == MDU_DIV) || (op_q == MDU_REM)) &&
                     (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
          // Signed overflow: quotient wraps to INT_MIN, remainder is zero.
          result_d = (op_q == MDU_DIV) ? 32'h8000_0000 : 32'd0;
          state_d  = S_DONE;
        end else begin
          a_d     = a_mag_s;
          b_d     = b_mag_s;
          qneg_d  = a_neg_s ^ b_neg_s;
          rneg_d  = a_neg_s;
          cnt_d   = 5'd31;
          acc_d   = op_is_div(op_q) ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (op_is_div(op_q)) begin
          // Restoring step: shift in the next dividend bit, subtract if it fits.
          if (!div_diff_s[XLEN]) begin
            acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          // Shift-add step: conditionally add multiplicand, shift product right.
          acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          state_d = S_CALC;
        end
      end

      S_FIX: begin
        case (op_q)
          MDU_MUL:                         result_d = prod_s[XLEN-1:0];
          MDU_MULH, MDU_MULHSU, MDU_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
          MDU_DIV, MDU_DIVU:               result_d = quo_s;
          MDU_REM, MDU_REMU:               result_d = rem_s;
          default:                         result_d = 32'd0;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= MDU_MUL;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
